// File: rtl/event_enkoder_pkg.sv
// Shared constants and helpers for the event encoder.
// Mode selectors, channel-count and one-hot utilities.
package event_enkoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int chan_count(input int n);
    return 1 << n;
  endfunction

  function automatic logic [255:0] onehot(input int unsigned idx);
    return 256'(1) << idx;
  endfunction

endpackage

// File: rtl/event_enkoder_prio_sel.sv
// Combinational channel picker: highest set bit, or
// lowest set bit of the vector rotated to begin at start.
module prio_sel
  import event_enkoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [chan_count(N)-1:0] vector,
  input  logic [N-1:0]             start,
  input  logic                     rr_en,
  output logic [N-1:0]             idx,
  output logic                     any
);

  localparam int CH = chan_count(N);

  logic [CH-1:0] w_rot;
  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_lo;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < CH; i++) begin
      w_rot[i] = vector[N'(i + int'(start))];
    end
  end

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < CH; i++) begin
      if (vector[i]) w_hi = N'(i);
    end
  end

  // Scan downward so the lowest rotated set bit wins.
  always_comb begin
    w_lo = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_lo = N'(i);
    end
  end

  assign any = |vector;
  assign idx = rr_en ? N'(w_lo + start) : w_hi;

endmodule

// File: rtl/event_enkoder.sv
// Sticky event latch presenting one pending channel index
// at a time over a registered valid/ready output.
module event_enkoder
  import event_enkoder_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = MODE_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [chan_count(N)-1:0] req,
  input  logic [chan_count(N)-1:0] mask,
  output logic [N-1:0]             out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [chan_count(N)-1:0] pending,
  output logic                     overflow
);

  localparam int CH = chan_count(N);

  logic [CH-1:0] r_pend;
  logic [N-1:0]  r_idx;
  logic          r_valid;
  logic          r_ovf;
  logic [N-1:0]  r_ptr;

  logic          w_hs;
  logic          w_load;
  logic [CH-1:0] w_clr;
  logic [CH-1:0] w_next;
  logic [CH-1:0] w_cand;
  logic [N-1:0]  w_ptr;
  logic [N-1:0]  w_start;
  logic [N-1:0]  w_sel;
  logic          w_any;

  assign w_hs   = r_valid & out_ready;
  assign w_load = ~r_valid | out_ready;
  assign w_clr  = w_hs ? CH'(onehot(int'(r_idx))) : '0;
  assign w_next = (r_pend & ~w_clr) | req;
  assign w_cand = w_next & ~mask;

  // The channel being accepted this edge is the new RR anchor.
  assign w_ptr   = w_hs ? r_idx : r_ptr;
  assign w_start = w_ptr + N'(1);

  prio_sel #(.N(N)) u_sel (
    .vector (w_cand),
    .start  (w_start),
    .rr_en  (MODE == MODE_RR),
    .idx    (w_sel),
    .any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_ptr   <= '1;
    end else begin
      r_pend <= w_next;
      r_ovf  <= |(req & r_pend & ~w_clr);
      r_ptr  <= w_ptr;
      if (w_load) begin
        r_valid <= w_any;
        r_idx   <= w_any ? w_sel : '0;
      end
    end
  end

  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign pending   = r_pend;
  assign overflow  = r_ovf;

endmodule

// File: doc/event_enkoder.md
Name: event_enkoder

Overview:
Sequential, parametrised successor to the combinational bit-index encoder. It latches request pulses from 2**N sources into a sticky pending vector and presents one pending source index at a time on a registered valid/ready output. Selection is either fixed-priority (highest index wins) or round-robin. It sits between interrupt/event sources and a single consumer, such as a sequencer or CPU port.

Parameters:
N, 3, index width; channel count is 2**N (N >= 1).
MODE, 0, 0 = fixed priority (highest set index wins), 1 = round-robin.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req  input  2**N  per-channel event pulses, sampled every edge
mask  input  2**N  1 = channel excluded from selection (still latched)
out_idx  output  N  index of the presented channel
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx when out_valid && out_ready
pending  output  2**N  current sticky pending vector (registered)
overflow  output  1  one-cycle pulse: a req hit an already-pending, not-being-cleared channel

Behaviour:
- Reset (rst=1 at an edge): pending=0, out_valid=0, out_idx=0, overflow=0, RR pointer=2**N-1. Takes priority over every other event, including mid-handshake; a held output is dropped.
- Handshake: hs = out_valid && out_ready. clr = one-hot(out_idx) if hs, else 0.
- Pending update: next_pending = (pending & ~clr) | req.
  - Simultaneous req and clear on the same bit: req wins; the bit stays pending and is delivered again later.
- Overflow: overflow <= |(req & pending & ~clr), registered, so it appears one cycle after the offending edge. Pending is unchanged by the duplicate.
- Selection: operates on cand = next_pending & ~mask.
  - MODE 0: out_idx = highest set index of cand.
  - MODE 1: out_idx = first set index scanning upward from ptr+1, wrapping modulo 2**N. ptr <= out_idx on each hs; ptr is otherwise unchanged.
- Output register:
  - Loads when (!out_valid || out_ready): out_valid <= |cand; out_idx <= selection (0 if cand == 0).
  - While out_valid && !out_ready, out_idx and out_valid are held stable. Newly arriving higher-priority requests and mask changes do not alter the held value; a held channel that becomes masked is still delivered.
- Latency:
  - req sampled at edge k -> out_valid high after edge k when the output register is idle.
  - Back-to-back: with out_ready=1 held, one index is delivered per cycle, and the next index appears the cycle after the handshake.
  - Mask cleared at edge k while idle -> out_valid after edge k.
- Widths: the index wraps modulo 2**N; no arithmetic overflow on ptr+1.
- pending reflects the register value, not next_pending.

Decomposition:
- Shared package: MODE_FIXED=0 and MODE_RR=1 constants; a function returning the channel count 2**N; an onehot(N-bit idx) helper function.
- One sub-module, prio_sel: combinational; inputs vector [2**N-1:0], start [N-1:0], rr_en; outputs idx and any.
  - Fixed mode: highest set bit.
  - RR mode: vector rotated by start, lowest set bit taken, index un-rotated.
  - Instantiated once; all state lives in event_enkoder.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF -> out_valid=0, pending=8'h00, overflow=0 throughout; after rst=0 with req=0 -> still idle.
2. N=3, MODE=0, out_ready=1: one-cycle req=8'b0010_0100 -> out_idx=5 with valid next cycle, then 2, then out_valid=0 and pending=0.
3. Hold stability, MODE=0:
   - req=8'h04, out_ready=0 -> out_idx=2 held.
   - Pulse req=8'h80 -> out_idx stays 2 and pending=8'h84.
   - Raise out_ready -> 2 is accepted, then 7.
4. MODE=1, out_ready=1:
   - One-cycle req=8'b1000_0011 -> sequence 0, 1, 7.
   - Then req=8'h06 -> 1, 2 (scan starts from ptr 7 +1, wrapping to 0).
   - Then req=8'h81 with ptr=2 -> 7, 0.
5. Overflow: req=8'h08 with out_ready=0 -> out_idx=3; pulse req=8'h08 again -> overflow=1 for exactly one cycle, pending=8'h08; repeat the same pulse in the cycle out_ready=1 -> no overflow, bit 3 re-pended, 3 delivered twice in total.
6. Mask: mask=8'h20, req=8'h20 -> pending=8'h20, out_valid=0; clear mask -> out_valid=1, out_idx=5 the next cycle; assert rst during the hold -> everything returns to reset values.
